ba201v32i_ifu: RTL and testbench
================================

Name: ba201v32i_ifu

Overview:
- Instruction fetch unit that sits directly upstream of the instruction TIM.
- Holds the PC and drives fetch address/valid into the TIM, whose read data returns combinationally in the same cycle.
- Captures each fetched word with its PC into a small in-order buffer and presents it to decode over a valid/ready handshake.
- Accepts redirects (branch/jump/trap) from execute, flushes stale entries, and flags misaligned redirect targets.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- FIFO_DEPTH, 2, fetch buffer entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- itim_o_valid  output  1  fetch request to the TIM this cycle
- itim_o_addr  output  32  byte address of the fetch; always equals the PC
- itim_i_rdata  input  32  instruction word, valid in the same cycle as itim_o_valid
- redirect_i_valid  input  1  redirect request from execute
- redirect_i_target  input  32  new PC
- if_o_valid  output  1  buffer head is valid
- if_o_pc  output  32  PC of head entry
- if_o_instr  output  32  instruction of head entry
- if_o_fault  output  1  head entry is a misaligned-fetch fault
- if_i_ready  input  1  decode accepts head this cycle

Behaviour:
- Reset values:
  - pc = RESET_VECTOR, count = 0, rd/wr pointers = 0, state = RUN.
  - itim_o_valid = 0 and if_o_valid = 0 while reset is high.
  - if_o_pc, if_o_instr and if_o_fault are don't-care while if_o_valid = 0.
- Reset asserted mid-operation discards all buffered entries and any pending fault at the next edge.
- States:
  - RUN: normal fetch.
  - FAULT: a fault entry is pending or has been issued; no fetching. Stays in FAULT until redirect_i_valid = 1.
- pop = if_o_valid & if_i_ready.
- fetch (combinational) = state RUN & ~reset & ~redirect_i_valid & (count < FIFO_DEPTH | pop).
  - itim_o_valid = fetch.
  - itim_o_addr = pc in every cycle.
- On fetch:
  - push {pc, itim_i_rdata, fault=0} at the write pointer.
  - pc <= pc + 4; 32-bit wrap, so 32'hFFFF_FFFC + 4 = 0.
- Simultaneous push and pop leaves count unchanged; pointers wrap modulo FIFO_DEPTH.
- Full buffer without pop: no fetch, pc holds. Empty buffer: if_o_valid = 0.
- Fetch-to-decode latency: a word fetched in cycle N is presented with if_o_valid = 1 in cycle N+1 at the earliest.
- Redirect (redirect_i_valid = 1) has the highest priority after reset:
  - Flush all entries (count <= 0), ignore any pop that cycle, issue no fetch that cycle.
  - pc <= redirect_i_target.
  - If target[1:0] == 0: state <= RUN; the first fetch from the target happens next cycle.
  - If target[1:0] != 0: state <= FAULT and push one entry {pc=target, instr=32'h0000_0013 (NOP), fault=1}; it is visible next cycle.
- While in FAULT:
  - No fetch.
  - The fault entry is popped normally; afterwards if_o_valid = 0 until the next redirect.
- A redirect in FAULT behaves exactly as in RUN.
- The head entry is stable while if_o_valid = 1 and if_i_ready = 0.

Test Plan:
- Reset release, if_i_ready = 1, TIM returns addr^32'hA5A5_0000: fetch addrs 0,4,8,... one per cycle; decode sees pc 0,4,8 from cycle 1 with matching instr, no bubbles.
- if_i_ready = 0 for 5 cycles after reset: exactly 2 pushes (pc 0,4); itim_o_valid = 0 from cycle 2 with addr held at 8. On ready = 1: pops in order 0,4,8 with fetch resuming in the same cycle as the first pop.
- Buffer holding pc 0x10,0x14, redirect to 0x200 with ready = 1: no pop counted, itim_o_valid = 0 that cycle; next cycle addr 0x200; decode next sees pc 0x200, never 0x10/0x14.
- Redirect to 0x202: next cycle if_o_valid = 1, pc = 0x202, fault = 1, instr = 0x13; after the pop, if_o_valid = 0 and no fetch for 10 cycles; redirect to 0x300 resumes fetch at 0x300.
- Redirect to 0xFFFF_FFFC then free-run: fetch addrs 0xFFFF_FFFC then 0x0000_0000.
- Reset asserted with a full buffer and FAULT pending: next cycle count = 0 and if_o_valid = 0; first fetch after release is at RESET_VECTOR.

Source files
------------

// File: rtl/ba201v32i_ifu.sv
// Instruction fetch unit: owns the PC, fetches from a same-cycle-response TIM,
// and buffers {pc, instr, fault} entries in order for decode.
module ba201v32i_ifu #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        itim_o_valid,
    output logic [31:0] itim_o_addr,
    input  logic [31:0] itim_i_rdata,
    input  logic        redirect_i_valid,
    input  logic [31:0] redirect_i_target,
    output logic        if_o_valid,
    output logic [31:0] if_o_pc,
    output logic [31:0] if_o_instr,
    output logic        if_o_fault,
    input  logic        if_i_ready
);

    localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned      CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      NOP     = 32'h0000_0013;

    typedef enum logic {
        RUN,
        FAULT
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    state_t             state;
    logic [31:0]        pc;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    entry_t             fifo_mem [FIFO_DEPTH];

    logic               pop;
    logic               fetch;
    logic               misaligned;
    logic               wr_en;
    logic [PTR_W-1:0]   wr_idx;
    entry_t             wr_data;
    entry_t             head;

    assign misaligned = (redirect_i_target[1:0] != 2'b00);

    // Gating with reset keeps the outputs quiet even before count is initialised.
    assign if_o_valid = ~reset & (count != '0);
    assign pop        = if_o_valid & if_i_ready;
    assign fetch      = (state == RUN) & ~reset & ~redirect_i_valid
                      & ((count < DEPTH_C) | pop);

    assign itim_o_valid = fetch;
    assign itim_o_addr  = pc;

    assign head       = fifo_mem[rd_ptr];
    assign if_o_pc    = head.pc;
    assign if_o_instr = head.instr;
    assign if_o_fault = head.fault;

    // A misaligned redirect lands its fault marker in slot 0 of the freshly flushed buffer.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        wr_en   = 1'b0;
        wr_idx  = wr_ptr;
        wr_data = '{pc: pc, instr: itim_i_rdata, fault: 1'b0};
        if (!reset) begin
            if (redirect_i_valid) begin
                wr_en   = misaligned;
                wr_idx  = '0;
                wr_data = '{pc: redirect_i_target, instr: NOP, fault: 1'b1};
            end else begin
                wr_en = fetch;
            end
        end
    end

    // NOTE: buffer storage carries no reset; count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            pc     <= RESET_VECTOR;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            state  <= RUN;
        end else if (redirect_i_valid) begin
            pc     <= redirect_i_target;
            rd_ptr <= '0;
            if (misaligned) begin
                state  <= FAULT;
                count  <= CNT_W'(1);
                wr_ptr <= PTR_W'(1);
            end else begin
                state  <= RUN;
                count  <= '0;
                wr_ptr <= '0;
            end
        end else begin
            if (fetch) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(fetch) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_ba201v32i_ifu.sv
// Directed bench for ba201v32i_ifu; a queue scoreboard holds the entries decode
// should see, filled as fetches are predicted and drained as decode pops.
module tb_ba201v32i_ifu;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam int          DEPTH        = 2;
    localparam logic [31:0] KEY          = 32'hA5A5_0000;
    localparam logic [31:0] NOP          = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        itim_o_valid;
    logic [31:0] itim_o_addr;
    logic [31:0] itim_i_rdata;
    logic        redirect_i_valid;
    logic [31:0] redirect_i_target;
    logic        if_o_valid;
    logic [31:0] if_o_pc;
    logic [31:0] if_o_instr;
    logic        if_o_fault;
    logic        if_i_ready;

    int          n_cmp = 0;
    int          n_err = 0;
    entry_t      sb_q[$];
    logic [31:0] model_pc;
    logic        model_fault;

    ba201v32i_ifu #(
        .RESET_VECTOR(RESET_VECTOR),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .itim_o_valid     (itim_o_valid),
        .itim_o_addr      (itim_o_addr),
        .itim_i_rdata     (itim_i_rdata),
        .redirect_i_valid (redirect_i_valid),
        .redirect_i_target(redirect_i_target),
        .if_o_valid       (if_o_valid),
        .if_o_pc          (if_o_pc),
        .if_o_instr       (if_o_instr),
        .if_o_fault       (if_o_fault),
        .if_i_ready       (if_i_ready)
    );

    always #5 clk = ~clk;

    // TIM model: read data is a fixed function of the requested address.
    assign itim_i_rdata = itim_o_addr ^ KEY;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs against the model, then advance past the edge.
    task automatic cycle(input logic rst, input logic rdy, input logic rv, input logic [31:0] tgt);
        logic exp_pop;
        logic exp_fetch;
        reset             = rst;
        if_i_ready        = rdy;
        redirect_i_valid  = rv;
        redirect_i_target = tgt;
        #1;
        if (rst) begin
            check("itim_valid_in_reset", 32'(itim_o_valid), 32'd0);
            check("if_valid_in_reset", 32'(if_o_valid), 32'd0);
            sb_q.delete();
            model_pc    = RESET_VECTOR;
            model_fault = 1'b0;
        end else begin
            exp_pop   = (sb_q.size() != 0) && rdy;
            exp_fetch = !model_fault && !rv && ((sb_q.size() < DEPTH) || exp_pop);
            check("itim_valid", 32'(itim_o_valid), 32'(exp_fetch));
            check("itim_addr", itim_o_addr, model_pc);
            check("if_valid", 32'(if_o_valid), 32'(sb_q.size() != 0));
            if (sb_q.size() != 0) begin
                check("head_pc", if_o_pc, sb_q[0].pc);
                check("head_instr", if_o_instr, sb_q[0].instr);
                check("head_fault", 32'(if_o_fault), 32'(sb_q[0].fault));
            end
            if (rv) begin
                sb_q.delete();
                model_pc    = tgt;
                model_fault = (tgt[1:0] != 2'b00);
                if (model_fault) sb_q.push_back('{pc: tgt, instr: NOP, fault: 1'b1});
            end else begin
                if (exp_pop) void'(sb_q.pop_front());
                if (exp_fetch) begin
                    sb_q.push_back('{pc: model_pc, instr: model_pc ^ KEY, fault: 1'b0});
                    model_pc = model_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Free-running fetch with decode always ready.
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0);

        // Decode stalled for 5 cycles: buffer fills to two, then drains in order.
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
        check("stall_addr_held", itim_o_addr, 32'h8);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0);

        // Buffer holding 0x10/0x14, then redirect to 0x200 with decode ready.
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        check("flush_head_pc", if_o_pc, 32'h10);
        cycle(0, 1, 1, 32'h200);
        check("redirect_addr", itim_o_addr, 32'h200);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);

        // Misaligned redirect: fault entry, then silence until the next redirect.
        cycle(0, 0, 1, 32'h202);
        check("fault_valid", 32'(if_o_valid), 32'd1);
        check("fault_pc", if_o_pc, 32'h202);
        check("fault_instr", if_o_instr, NOP);
        check("fault_flag", 32'(if_o_fault), 32'd1);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 32'h300);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);

        // PC wrap at the top of the address space.
        cycle(0, 1, 1, 32'hFFFF_FFFC);
        check("wrap_first_addr", itim_o_addr, 32'hFFFF_FFFC);
        cycle(0, 1, 0, 0);
        check("wrap_second_addr", itim_o_addr, 32'h0000_0000);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);

        // Full buffer, then pending fault, then reset discards everything.
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 32'h101);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("post_reset_if_valid", 32'(if_o_valid), 32'd0);
        cycle(1, 1, 0, 0);
        check("post_reset_addr", itim_o_addr, RESET_VECTOR);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
